// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between a load/store initiator and the data memory responder.
interface data_mem_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding byte-addressed little-endian data memory with fixed response latency.
module data_mem_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, uns_q, err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q, a1, a2, a3;
    logic [WIDTH-1:0]      wdata_q, rdata_q, load_val;
    logic                  bad, accept, commit;
    logic [31:0]           word, v32;
    logic [7:0]            mem_q [2**ADDR_WIDTH];
    logic                  unused_addr;

    assign unused_addr = ^bus.req_addr[WIDTH-1:ADDR_WIDTH];
    assign accept = bus.req_valid && bus.req_ready;
    assign bad = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) ||
                 (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    assign a1 = addr_q + ADDR_WIDTH'(1);
    assign a2 = addr_q + ADDR_WIDTH'(2);
    assign a3 = addr_q + ADDR_WIDTH'(3);
    assign word = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[addr_q]};
    // Extend to 32 bits by size first, then to WIDTH by signedness
    assign v32 = size_q == 2'b00 ? {{24{!uns_q && word[7]}}, word[7:0]} :
                 size_q == 2'b01 ? {{16{!uns_q && word[15]}}, word[15:0]} : word;
    assign load_val = uns_q ? WIDTH'(v32) : WIDTH'($signed(v32));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY - 1);
            end
            BUSY: if (cnt_q == 4'd0) begin
                state_d = RESP;
                commit  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr[ADDR_WIDTH-1:0];
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
            end
            if (commit) begin
                rdata_q <= (we_q || bad) ? '0 : load_val;
                err_q   <= bad;
            end
        end
    end

    // Store commits on entry to RESP; a reset on that edge drops it
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !bad) begin
            mem_q[addr_q] <= wdata_q[7:0];
            if (size_q != 2'b00) mem_q[a1] <= wdata_q[15:8];
            if (size_q == 2'b10) begin
                mem_q[a2] <= wdata_q[23:16];
                mem_q[a3] <= wdata_q[31:24];
            end
        end
    end

    assign bus.req_ready  = state_q == IDLE && !rst;
    assign bus.resp_valid = state_q == RESP && !rst;
    assign bus.resp_rdata = bus.resp_valid ? rdata_q : '0;
    assign bus.resp_err   = bus.resp_valid && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench with a byte-array reference model.
module tb_data_mem_responder;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   hold = 0;
    bit   rnd_bp = 0;
    bit   in_resp = 0;
    logic [31:0] held_rd;
    logic        held_err;
    logic [7:0]  ref_mem [4096];
    exp_t        sb [$];

    data_mem_if #(.WIDTH(32)) bus ();

    data_mem_responder #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.resp_ready = hold ? 1'b0 : rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Reference: decode error, then byte-wise little-endian access with wrap
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  output logic err, output logic [31:0] rd);
        int a  = int'(addr[11:0]);
        int nb = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        err = size == 2'd3 || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
        rd  = 0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[(a + i) % 4096] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[(a + i) % 4096];
            if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            in_resp = 0;
        end else if (bus.resp_valid) begin
            if (!in_resp) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    chk("latency", 32'(cyc - sb[0].cyc), 32'(LAT));
                    chk("rdata", bus.resp_rdata, sb[0].rd);
                    chk("err", 32'(bus.resp_err), 32'(sb[0].err));
                end
                held_rd  = bus.resp_rdata;
                held_err = bus.resp_err;
                in_resp  = 1;
            end else begin
                chk("hold_rdata", bus.resp_rdata, held_rd);
                chk("hold_err", 32'(bus.resp_err), 32'(held_err));
                chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            end
            if (bus.resp_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                in_resp = 0;
            end
        end else begin
            if (in_resp) chk("resp_dropped", 32'(bus.resp_valid), 32'd1);
            in_resp = 0;
            chk("idle_outputs", {bus.resp_rdata[30:0], bus.resp_err}, 32'd0);
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input bit push,
                         input bit use_exp, input logic [31:0] xrd, input logic xerr);
        int   n = 0;
        exp_t e;
        logic merr;
        logic [31:0] mrd;
        @(negedge clk);
        bus.req_we = we;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_valid = 1;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 0;
            return;
        end
        if (push) begin
            model(we, addr, wdata, size, uns, merr, mrd);
            e.rd  = use_exp ? xrd : mrd;
            e.err = use_exp ? xerr : merr;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 0;
        bus.req_we = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || bus.resp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || bus.resp_valid) begin
            chk("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic dir(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [31:0] xrd, input logic xerr);
        issue(we, addr, wdata, size, uns, 1, 1, xrd, xerr);
        wait_done();
    endtask

    initial begin
        bus.req_valid = 0;
        bus.req_we = 0;
        bus.req_addr = 0;
        bus.req_wdata = 0;
        bus.req_size = 0;
        bus.req_unsigned = 0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {28'd0, bus.req_ready, bus.resp_valid, bus.resp_err, |bus.resp_rdata}, 32'd0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        dir(1, 32'h010, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0);
        dir(0, 32'h010, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0);
        dir(0, 32'h013, 32'h0, 2'd0, 0, 32'hFFFFFFDE, 0);
        dir(0, 32'h013, 32'h0, 2'd0, 1, 32'h000000DE, 0);
        dir(0, 32'h010, 32'h0, 2'd1, 0, 32'hFFFFBEEF, 0);
        dir(0, 32'h012, 32'h0, 2'd1, 1, 32'h0000DEAD, 0);
        dir(1, 32'h011, 32'h5A, 2'd0, 0, 32'h0, 0);
        dir(0, 32'h010, 32'h0, 2'd2, 0, 32'hDEAD5AEF, 0);
        dir(1, 32'h012, 32'h12345678, 2'd2, 0, 32'h0, 1);
        dir(0, 32'h010, 32'h0, 2'd2, 0, 32'hDEAD5AEF, 0);
        dir(0, 32'h7010, 32'h0, 2'd2, 0, 32'hDEAD5AEF, 0);
        dir(0, 32'h011, 32'h0, 2'd1, 0, 32'h0, 1);
        dir(0, 32'h010, 32'h0, 2'd3, 0, 32'h0, 1);

        for (int a = 0; a < 64; a += 4) begin
            issue(1, 32'(a), $urandom, 2'd2, 0, 1, 0, 0, 0);
            wait_done();
        end
        issue(1, 32'hFFC, $urandom, 2'd2, 0, 1, 0, 0, 0);
        wait_done();

        hold = 1;
        issue(0, 32'h020, 32'h0, 2'd2, 0, 1, 0, 0, 0);
        for (int n = 0; n < 20 && !bus.resp_valid; n++) @(negedge clk);
        chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(bus.resp_valid), 32'd1);
        end
        hold = 0;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.resp_valid & bus.resp_ready), 32'd1);
        @(negedge clk);
        chk("bp_idle_ready", {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
        wait_done();

        issue(1, 32'h020, 32'h11111111, 2'd2, 0, 0, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_outputs", {28'd0, bus.req_ready, bus.resp_valid, bus.resp_err, |bus.resp_rdata}, 32'd0);
        @(negedge clk);
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        dir(0, 32'h020, 32'h0, 2'd2, 0, {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]}, 0);

        rnd_bp = 1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] r = $urandom;
            logic [11:0] off = ($urandom_range(0, 4) == 0) ? 12'hFFC + 12'($urandom_range(0, 3))
                                                         : 12'($urandom_range(0, 63));
            issue(1'($urandom), {r[31:12], off}, $urandom, 2'($urandom), 1'($urandom), 1, 0, 0, 0);
            wait_done();
        end
        rnd_bp = 0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
